// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron training controller: mode codes, FSM states
// and default phase lengths derived from the input count.
package neuron_pkg;

    localparam logic [1:0] MODE_FSETUP = 2'b00;
    localparam logic [1:0] MODE_FWD    = 2'b10;
    localparam logic [1:0] MODE_BSETUP = 2'b11;
    localparam logic [1:0] MODE_BWD    = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FSETUP,
        ST_FWD,
        ST_BSETUP,
        ST_BWD,
        ST_COMMIT,
        ST_RESULT
    } state_e;

    function automatic int fwd_cyc_default(input int n);
        return n / 2 + 4;
    endfunction

    function automatic int bwd_cyc_default(input int n);
        return n + 4;
    endfunction

endpackage

// File: rtl/neuron_train_ctrl_if.sv
// Sample, result, weight-init and neuron-operand signals of the training controller.
// The ctrl modport is the controller side; env is the source/sink/neuron side.
interface neuron_train_ctrl_if #(
    parameter int N    = 30,
    parameter int BITS = 16
);
    logic                       s_valid;
    logic                       s_ready;
    logic [N-1:0][BITS-1:0]     s_x;
    logic [BITS-1:0]            s_y_true;
    logic                       s_train;
    logic [BITS-1:0]            lr;

    logic                       init_we;
    logic [4:0]                 init_idx;
    logic [BITS-1:0]            init_data;

    logic                       n_FP;
    logic                       n_BP;
    logic [N-1:0][BITS-1:0]     n_x;
    logic [N-1:0][BITS-1:0]     n_w;
    logic [BITS-1:0]            n_b;
    logic [BITS-1:0]            n_y_true;
    logic [BITS-1:0]            n_lr;
    logic [BITS-1:0]            n_y;
    logic                       n_yhat;
    logic [BITS-1:0]            n_dz;
    logic [N:0][BITS-1:0]       n_W_out;

    logic                       r_valid;
    logic                       r_ready;
    logic [BITS-1:0]            r_y;
    logic [BITS-1:0]            r_dz;
    logic                       r_yhat;
    logic                       busy;

    modport ctrl (
        input  s_valid, s_x, s_y_true, s_train, lr,
        input  init_we, init_idx, init_data,
        input  n_y, n_yhat, n_dz, n_W_out,
        input  r_ready,
        output s_ready,
        output n_FP, n_BP, n_x, n_w, n_b, n_y_true, n_lr,
        output r_valid, r_y, r_dz, r_yhat, busy
    );

    modport env (
        output s_valid, s_x, s_y_true, s_train, lr,
        output init_we, init_idx, init_data,
        output n_y, n_yhat, n_dz, n_W_out,
        output r_ready,
        input  s_ready,
        input  n_FP, n_BP, n_x, n_w, n_b, n_y_true, n_lr,
        input  r_valid, r_y, r_dz, r_yhat, busy
    );

endinterface

// File: rtl/neuron_weight_store.sv
// (N+1)-entry weight/bias register file: entry 0 is the bias, entry k is w[k-1].
// One write port that either takes a single init word or the whole committed vector.
module neuron_weight_store #(
    parameter int N    = 30,
    parameter int BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [4:0]           wr_idx_i,
    input  logic [BITS-1:0]      wr_data_i,
    input  logic                 commit_i,
    input  logic [N:0][BITS-1:0] commit_data_i,
    output logic [N:0][BITS-1:0] rd_data_o
);
    localparam int unsigned DEPTH = N + 1;

    logic [N:0][BITS-1:0] mem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (commit_i) begin
            mem_q <= commit_data_i;
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_idx_i == 5'(i)) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    assign rd_data_o = mem_q;

endmodule

// File: rtl/neuron_train_ctrl.sv
// Sequences one sigmoid neuron through forward/backward phases for a sample,
// captures its results and commits the updated weights into the local store.
module neuron_train_ctrl
    import neuron_pkg::*;
#(
    parameter int N       = 30,
    parameter int BITS    = 16,
    parameter int FWD_CYC = fwd_cyc_default(N),
    parameter int BWD_CYC = bwd_cyc_default(N)
) (
    input  logic             clk,
    input  logic             rst,
    neuron_train_ctrl_if.ctrl bus
);
    localparam logic [4:0] IDX_MAX = 5'(N);

    state_e                 state_q, state_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [1:0]             mode;

    logic [N-1:0][BITS-1:0] x_q;
    logic [BITS-1:0]        y_true_q;
    logic                   train_q;
    logic [BITS-1:0]        r_y_q;
    logic [BITS-1:0]        r_dz_q;
    logic                   r_yhat_q;

    logic                   accept;
    logic                   fwd_last;
    logic                   bwd_last;
    logic                   init_wr;
    logic                   commit;
    logic [N:0][BITS-1:0]   store_rd;

    assign accept   = (state_q == ST_IDLE) && bus.s_valid;
    assign fwd_last = (state_q == ST_FWD) && (cnt_q == 6'd1);
    assign bwd_last = (state_q == ST_BWD) && (cnt_q == 6'd1);
    assign commit   = (state_q == ST_COMMIT);
    assign init_wr  = (state_q == ST_IDLE) && bus.init_we && (bus.init_idx <= IDX_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode    = MODE_FSETUP;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.s_valid) state_d = ST_FSETUP;
            end
            ST_FSETUP: begin
                state_d = ST_FWD;
                cnt_d   = 6'(FWD_CYC);
            end
            ST_FWD: begin
                mode  = MODE_FWD;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = train_q ? ST_BSETUP : ST_RESULT;
            end
            ST_BSETUP: begin
                mode    = MODE_BSETUP;
                state_d = ST_BWD;
                cnt_d   = 6'(BWD_CYC);
            end
            ST_BWD: begin
                mode  = MODE_BWD;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (bus.r_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_true_q <= '0;
            train_q  <= 1'b0;
            r_y_q    <= '0;
            r_dz_q   <= '0;
            r_yhat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                x_q      <= bus.s_x;
                y_true_q <= bus.s_y_true;
                train_q  <= bus.s_train;
            end
            // Inference never reaches the backward phase, so dZ is zeroed here.
            if (fwd_last) begin
                r_y_q    <= bus.n_y;
                r_yhat_q <= bus.n_yhat;
                if (!train_q) r_dz_q <= '0;
            end
            if (bwd_last) begin
                r_dz_q <= bus.n_dz;
            end
        end
    end

    neuron_weight_store #(
        .N    (N),
        .BITS (BITS)
    ) u_store (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (init_wr),
        .wr_idx_i      (bus.init_idx),
        .wr_data_i     (bus.init_data),
        .commit_i      (commit),
        .commit_data_i (bus.n_W_out),
        .rd_data_o     (store_rd)
    );

    assign bus.s_ready  = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.r_valid  = (state_q == ST_RESULT);
    assign bus.r_y      = r_y_q;
    assign bus.r_dz     = r_dz_q;
    assign bus.r_yhat   = r_yhat_q;

    assign bus.n_FP     = mode[1];
    assign bus.n_BP     = mode[0];
    assign bus.n_x      = x_q;
    assign bus.n_y_true = y_true_q;
    assign bus.n_lr     = bus.lr;
    assign bus.n_b      = store_rd[0];
    assign bus.n_w      = store_rd[N:1];

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Directed bench for neuron_train_ctrl with a behavioural neuron stub that only
// answers with valid results in the mode where the controller should sample them.
module tb_neuron_train_ctrl;
    localparam int N    = 30;
    localparam int BITS = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    neuron_train_ctrl_if #(.N(N), .BITS(BITS)) bus ();

    neuron_train_ctrl #(.N(N), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stub: y = 0.5 + b in forward modes, dz = y - y_true in BWD mode,
    // W_out[0] = b + dz, W_out[k] = w[k-1] + dz*x[k-1].
    logic [BITS-1:0] y_fwd, dz_calc;
    logic [31:0]     prod;
    always_comb begin
        y_fwd       = 16'h0080 + bus.n_b;
        dz_calc     = y_fwd - bus.n_y_true;
        prod        = '0;
        bus.n_y     = bus.n_FP ? y_fwd : 16'hDEAD;
        bus.n_yhat  = bus.n_FP && ($signed(y_fwd) >= $signed(16'h0080));
        bus.n_dz    = (!bus.n_FP && bus.n_BP) ? dz_calc : 16'hBEEF;
        bus.n_W_out = '0;
        bus.n_W_out[0] = bus.n_b + dz_calc;
        for (int unsigned k = 1; k <= N; k++) begin
            prod = 32'($signed(dz_calc) * $signed(bus.n_x[k-1]));
            bus.n_W_out[k] = bus.n_w[k-1] + prod[23:8];
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc;
    logic       inj_en = 1'b0;
    logic [1:0] modes [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_store_zero(input string tag);
        logic [BITS-1:0] acc;
        acc = bus.n_b;
        for (int unsigned k = 0; k < N; k++) acc = acc | bus.n_w[k];
        chk(tag, 32'(acc), 32'h0);
    endtask

    task automatic accept(input logic train);
        @(negedge clk);
        bus.s_train = train;
        bus.s_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until r_valid, bounded at 200.
    task automatic run_to_result(output int n);
        n = 0;
        modes[0] = {bus.n_FP, bus.n_BP};
        while (!bus.r_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n < 64) modes[n] = {bus.n_FP, bus.n_BP};
            if (inj_en && n == 3) begin
                bus.init_we   = 1'b1;
                bus.init_idx  = 5'd3;
                bus.init_data = 16'h1234;
            end
            if (inj_en && n == 4) begin
                chk("fwd_init_ignored", 32'(bus.n_w[2]), 32'h0);
                bus.init_we = 1'b0;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.r_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.r_ready = 1'b0;
    endtask

    initial begin
        logic [BITS-1:0] ry, rdz;
        logic            ryh;
        logic            saw_valid;

        bus.s_valid = 1'b0; bus.s_x = '0; bus.s_y_true = '0; bus.s_train = 1'b0;
        bus.lr = 16'h0100; bus.init_we = 1'b0; bus.init_idx = '0; bus.init_data = '0;
        bus.r_ready = 1'b0;

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'h1);
        chk("rst_mode", 32'({bus.n_FP, bus.n_BP}), 32'h0);
        chk("rst_r_valid", 32'(bus.r_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_r_y", 32'({bus.r_y, bus.r_dz, 15'd0, bus.r_yhat}), 32'h0);
        chk_store_zero("rst_store");

        // Inference with zero weights
        for (int k = 0; k < N; k++) bus.s_x[k] = 16'(k * 37 + 5);
        bus.s_y_true = 16'h0042;
        accept(1'b0);
        chk("inf_busy", 32'(bus.busy), 32'h1);
        chk("inf_nx0", 32'(bus.n_x[0]), 32'h0005);
        chk("inf_nx29", 32'(bus.n_x[29]), 32'(16'(29 * 37 + 5)));
        bus.s_x = '0;
        run_to_result(cyc);
        chk("inf_latency", 32'(cyc), 32'd20);
        chk("inf_mode_c0", 32'(modes[0]), 32'h0);
        chk("inf_mode_c1", 32'(modes[1]), 32'h2);
        chk("inf_mode_c19", 32'(modes[19]), 32'h2);
        chk("inf_r_y", 32'(bus.r_y), 32'h0080);
        chk("inf_r_yhat", 32'(bus.r_yhat), 32'h1);
        chk("inf_r_dz", 32'(bus.r_dz), 32'h0);
        chk("inf_ny_true", 32'(bus.n_y_true), 32'h0042);
        consume();
        chk("inf_idle_s_ready", 32'(bus.s_ready), 32'h1);
        chk("inf_idle_r_valid", 32'(bus.r_valid), 32'h0);
        chk_store_zero("inf_store_unchanged");

        // Training, x[0] = 1.0, y_true = 1.0, with init write attempted during FWD
        bus.s_x = '0;
        bus.s_x[0] = 16'h0100;
        bus.s_y_true = 16'h0100;
        inj_en = 1'b1;
        accept(1'b1);
        bus.s_x = '0;
        run_to_result(cyc);
        inj_en = 1'b0;
        chk("trn_latency", 32'(cyc), 32'd56);
        chk("trn_mode_c0", 32'(modes[0]), 32'h0);
        chk("trn_mode_c1", 32'(modes[1]), 32'h2);
        chk("trn_mode_c19", 32'(modes[19]), 32'h2);
        chk("trn_mode_c20", 32'(modes[20]), 32'h3);
        chk("trn_mode_c21", 32'(modes[21]), 32'h1);
        chk("trn_mode_c54", 32'(modes[54]), 32'h1);
        chk("trn_mode_c55", 32'(modes[55]), 32'h0);
        chk("trn_r_dz", 32'(bus.r_dz), 32'hFF80);
        chk("trn_r_y", 32'(bus.r_y), 32'h0080);
        chk("trn_r_yhat", 32'(bus.r_yhat), 32'h1);
        chk("trn_n_lr", 32'(bus.n_lr), 32'h0100);

        // Backpressure with a competing sample offered
        ry = bus.r_y; rdz = bus.r_dz; ryh = bus.r_yhat;
        bus.s_x[0] = 16'h7777;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_r_valid", 32'(bus.r_valid), 32'h1);
            chk("bp_s_ready", 32'(bus.s_ready), 32'h0);
            chk("bp_outputs", 32'({bus.r_y, bus.r_dz} ^ {ry, rdz}) | 32'(bus.r_yhat ^ ryh), 32'h0);
        end
        chk("bp_nx_held", 32'(bus.n_x[0]), 32'h0100);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_x = '0;
        consume();
        chk("trn_idle_s_ready", 32'(bus.s_ready), 32'h1);
        chk("trn_idle_r_valid", 32'(bus.r_valid), 32'h0);
        chk("trn_store_b", 32'(bus.n_b), 32'hFF80);
        chk("trn_store_w0", 32'(bus.n_w[0]), 32'hFF80);
        chk("trn_store_w2", 32'(bus.n_w[2]), 32'h0);
        begin
            logic [BITS-1:0] acc;
            acc = '0;
            for (int k = 1; k < N; k++) acc = acc | bus.n_w[k];
            chk("trn_store_rest", 32'(acc), 32'h0);
        end

        // Inference with the committed bias: y = 0.5 - 0.5 = 0
        accept(1'b0);
        run_to_result(cyc);
        chk("inf2_latency", 32'(cyc), 32'd20);
        chk("inf2_r_y", 32'(bus.r_y), 32'h0000);
        chk("inf2_r_yhat", 32'(bus.r_yhat), 32'h0);
        chk("inf2_r_dz_cleared", 32'(bus.r_dz), 32'h0);
        consume();

        // Init writes in IDLE
        @(negedge clk);
        bus.init_we = 1'b1; bus.init_idx = 5'd3; bus.init_data = 16'h1234;
        @(posedge clk);
        #1;
        chk("idle_init_w2", 32'(bus.n_w[2]), 32'h1234);
        @(negedge clk);
        bus.init_idx = 5'd31; bus.init_data = 16'h5555;
        @(posedge clk);
        #1;
        bus.init_we = 1'b0;
        chk("idx31_b", 32'(bus.n_b), 32'hFF80);
        chk("idx31_w29", 32'(bus.n_w[29]), 32'h0);
        chk("idx31_w2", 32'(bus.n_w[2]), 32'h1234);

        // Reset during the 5th BWD cycle
        bus.s_x[0] = 16'h0100;
        accept(1'b1);
        repeat (25) begin
            @(posedge clk);
        end
        #1;
        chk("mid_bwd_mode", 32'({bus.n_FP, bus.n_BP}), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_mode", 32'({bus.n_FP, bus.n_BP}), 32'h0);
        chk("mid_rst_s_ready", 32'(bus.s_ready), 32'h1);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk_store_zero("mid_rst_store");
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | bus.r_valid | bus.busy;
        end
        chk("mid_rst_no_result", 32'(saw_valid), 32'h0);
        chk_store_zero("mid_rst_store_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
